// File: rtl/logic_arb.sv
// Purpose: round-robin arbiter sharing one bitwise logic unit (AND/OR/XOR/NAND) among 4 requesters; optional op counter under LOGIC_ARB_CNT_EN.
// Latency: grant edge -> rsp_valid after 2 edges; one operation in flight, min issue interval 3 cycles.
// Backpressure: result held in RESP until rsp_ready; req_ready stays low until the response is accepted.
module logic_arb #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         req_valid,
   output logic [3:0]         req_ready,
   input  logic [7:0]         req_op,
   input  logic [4*WIDTH-1:0] req_a,
   input  logic [4*WIDTH-1:0] req_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [1:0]         rsp_id,
   output logic [WIDTH-1:0]   rsp_y
`ifdef LOGIC_ARB_CNT_EN
   ,
   output logic [15:0]        op_count
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state;
   logic [1:0]       ptr;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [1:0]       id_q;

   logic [1:0]       win;
   logic             found;
   logic [1:0]       idx;

   logic [WIDTH-1:0] a_arr  [4];
   logic [WIDTH-1:0] b_arr  [4];
   logic [1:0]       op_arr [4];

   // Unpack the per-requester operand and opcode lanes
   for (genvar g = 0; g < 4; g++) begin : g_unpack
      assign a_arr[g]  = req_a[WIDTH*g +: WIDTH];
      assign b_arr[g]  = req_b[WIDTH*g +: WIDTH];
      assign op_arr[g] = req_op[2*g +: 2];
   end

   // Round-robin search starting at the pointer; first valid requester wins
   always_comb begin
      win   = ptr;
      found = 1'b0;
      idx   = ptr;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + k[1:0];
         if (!found && req_valid[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   // Grant is only offered from IDLE and never while reset is held
   always_comb begin
      req_ready = 4'b0000;
      if (state == IDLE && !rst && found) begin
         req_ready[win] = 1'b1;
      end
   end

   // Control FSM: capture on grant, compute in EXEC, hold result in RESP
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 2'd0;
         op_q      <= 2'd0;
         a_q       <= '0;
         b_q       <= '0;
         id_q      <= 2'd0;
         rsp_valid <= 1'b0;
         rsp_id    <= 2'd0;
         rsp_y     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  op_q  <= op_arr[win];
                  a_q   <= a_arr[win];
                  b_q   <= b_arr[win];
                  id_q  <= win;
                  ptr   <= win + 2'd1;
                  state <= EXEC;
               end
            end
            EXEC: begin
               case (op_q)
                  2'b00:   rsp_y <= a_q & b_q;
                  2'b01:   rsp_y <= a_q | b_q;
                  2'b10:   rsp_y <= a_q ^ b_q;
                  default: rsp_y <= ~(a_q & b_q);
               endcase
               rsp_id    <= id_q;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

`ifdef LOGIC_ARB_CNT_EN
   // Count completed response handshakes; wraps naturally at 16 bits
   always_ff @(posedge clk) begin
      if (rst) begin
         op_count <= 16'd0;
      end else if (rsp_valid && rsp_ready) begin
         op_count <= op_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_logic_arb.sv
// Purpose: directed self-checking bench for logic_arb (grant, opcodes, round-robin, stall, reset, counter).
// Latency: checks rsp_valid exactly 2 edges after the grant edge.
// Backpressure: holds rsp_ready low in RESP and checks the result stays stable.
module tb_logic_arb;

   localparam int WIDTH = 8;

   logic               clk;
   logic               rst;
   logic [3:0]         req_valid;
   logic [3:0]         req_ready;
   logic [7:0]         req_op;
   logic [4*WIDTH-1:0] req_a;
   logic [4*WIDTH-1:0] req_b;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [1:0]         rsp_id;
   logic [WIDTH-1:0]   rsp_y;
`ifdef LOGIC_ARB_CNT_EN
   logic [15:0]        op_count;
`endif

   int total = 0;
   int bad   = 0;

   logic_arb #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y)
`ifdef LOGIC_ARB_CNT_EN
      ,
      .op_count  (op_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One operation with rsp_ready high; inputs are scrambled after the grant
   // and restored afterwards. Returns at a falling edge with the FSM in IDLE.
   task automatic run_op(input logic [3:0] vld, input logic [3:0] exp_gnt,
                         input logic [1:0] exp_id, input logic [7:0] exp_y,
                         input bit hold);
      logic [7:0]         sv_op;
      logic [4*WIDTH-1:0] sv_a;
      logic [4*WIDTH-1:0] sv_b;
      sv_op = req_op;
      sv_a  = req_a;
      sv_b  = req_b;
      req_valid = vld;
      rsp_ready = 1'b1;
      #1;
      chk("grant", {28'd0, req_ready}, {28'd0, exp_gnt});
      @(negedge clk);
      if (!hold) req_valid = 4'b0000;
      req_op = ~sv_op;
      req_a  = ~sv_a;
      req_b  = ~sv_b;
      #1;
      chk("exec_rdy", {28'd0, req_ready}, 32'd0);
      chk("exec_vld", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("rsp_vld", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_id", {30'd0, rsp_id}, {30'd0, exp_id});
      chk("rsp_y", {24'd0, rsp_y}, {24'd0, exp_y});
      @(negedge clk);
      req_op = sv_op;
      req_a  = sv_a;
      req_b  = sv_b;
      chk("rsp_done", {31'd0, rsp_valid}, 32'd0);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 4'hF;
      rsp_ready = 1'b0;
      req_op    = 8'b11_10_01_00;
      req_a     = {4{8'hAA}};
      req_b     = {4{8'h0F}};

      // Reset state, with every request pending
      @(negedge clk);
      @(negedge clk);
      chk("rst_rdy", {28'd0, req_ready}, 32'd0);
      chk("rst_vld", {31'd0, rsp_valid}, 32'd0);
      chk("rst_id", {30'd0, rsp_id}, 32'd0);
      chk("rst_y", {24'd0, rsp_y}, 32'd0);
      rst       = 1'b0;
      req_valid = 4'b0000;
      @(negedge clk);

      // Single request from requester 1: F0 AND 3C
      req_a[15:8] = 8'hF0;
      req_b[15:8] = 8'h3C;
      req_op[3:2] = 2'b00;
      run_op(4'b0010, 4'b0010, 2'd1, 8'h30, 1'b0);
      req_a[15:8] = 8'hAA;
      req_b[15:8] = 8'h0F;
      req_op[3:2] = 2'b01;

      // Opcodes on requester 0: OR, XOR, NAND
      req_op[1:0] = 2'b01;
      run_op(4'b0001, 4'b0001, 2'd0, 8'hAF, 1'b0);
      req_op[1:0] = 2'b10;
      run_op(4'b0001, 4'b0001, 2'd0, 8'hA5, 1'b0);
      req_op[1:0] = 2'b11;
      run_op(4'b0001, 4'b0001, 2'd0, 8'hF5, 1'b0);
      req_op[1:0] = 2'b00;

      // Round-robin with all requests held: 0,1,2,3 then wrap to 0
      do_reset();
      run_op(4'hF, 4'b0001, 2'd0, 8'h0A, 1'b1);
      run_op(4'hF, 4'b0010, 2'd1, 8'hAF, 1'b1);
      run_op(4'hF, 4'b0100, 2'd2, 8'hA5, 1'b1);
      run_op(4'hF, 4'b1000, 2'd3, 8'hF5, 1'b1);
      run_op(4'hF, 4'b0001, 2'd0, 8'h0A, 1'b0);

      // Backpressure on requester 2 (XOR -> A5); others request during the stall
      req_valid = 4'b0100;
      rsp_ready = 1'b0;
      #1;
      chk("bp_grant", {28'd0, req_ready}, 32'h4);
      @(negedge clk);
      req_valid = 4'hF;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("bp_vld", {31'd0, rsp_valid}, 32'd1);
         chk("bp_y", {24'd0, rsp_y}, 32'hA5);
         chk("bp_id", {30'd0, rsp_id}, 32'd2);
         chk("bp_rdy", {28'd0, req_ready}, 32'd0);
         @(negedge clk);
      end
      req_valid = 4'b0000;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_rel_vld", {31'd0, rsp_valid}, 32'd0);
      req_valid = 4'b0001;
      #1;
      chk("bp_idle_gnt", {28'd0, req_ready}, 32'h1);
      req_valid = 4'b0000;
      @(negedge clk);

      // Reset while in EXEC: no response, pointer returns to 0
      req_valid = 4'b0010;
      #1;
      chk("mid_grant", {28'd0, req_ready}, 32'h2);
      @(negedge clk);
      req_valid = 4'b0000;
      rst       = 1'b1;
      #1;
      chk("mid_rst_rdy", {28'd0, req_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
         @(negedge clk);
      end
      run_op(4'hF, 4'b0001, 2'd0, 8'h0A, 1'b0);

`ifdef LOGIC_ARB_CNT_EN
      do_reset();
      chk("cnt_rst", {16'd0, op_count}, 32'd0);
      run_op(4'b0100, 4'b0100, 2'd2, 8'hA5, 1'b0);
      run_op(4'b1000, 4'b1000, 2'd3, 8'hF5, 1'b0);
      run_op(4'b0010, 4'b0010, 2'd1, 8'hAF, 1'b0);
      chk("cnt_three", {16'd0, op_count}, 32'd3);
      do_reset();
      chk("cnt_clr", {16'd0, op_count}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
